// File: rtl/seven_segment_pkg.sv
// Shared definitions for the seven-segment scanner: scan phase type,
// segment bit positions, the logical "all off" pattern and the hex decode table.
package seven_segment_pkg;

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_DRIVE = 1'b1
  } scan_phase_t;

  // Bit positions inside the 8-bit segment bus {a,b,c,d,e,f,g,dp}
  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  // Logical (active-high) pattern with every segment and dp dark;
  // the board-level inactive level is this XORed with the polarity mask.
  localparam logic [7:0] SEG_LOGIC_OFF = 8'h00;

  // Hex digit to segments a..g, logical active-high, a in bit 6
  function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seven_segment_scanner_if.sv
// Bus between the data path and the scanner. The data side (master) drives
// enable/load/value/dp_in/blank_in; the scanner (slave) drives the pins,
// the slot index, the frame pulse and its scan phase for observation.
//
// Handshake: load is a plain one-cycle strobe with no ready; whatever is on
// value/dp_in/blank_in at a clock edge with load high is captured into the
// pending buffer, unconditionally, whether or not scanning is enabled.
interface seven_segment_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  import seven_segment_pkg::*;

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                    enable;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic [7:0]              seg;
  logic [NUM_DIGITS-1:0]   an;
  logic [IDX_W-1:0]        digit_idx;
  logic                    frame_tick;
  scan_phase_t             phase;

  modport master (
    output enable, load, value, dp_in, blank_in,
    input  seg, an, digit_idx, frame_tick, phase
  );

  modport slave (
    input  enable, load, value, dp_in, blank_in,
    output seg, an, digit_idx, frame_tick, phase
  );

endinterface

// File: rtl/seven_segment_decoder.sv
// Combinational hex digit + decimal point to logical 8-bit segment pattern.
module seven_segment_decoder
  import seven_segment_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [6:0] code;

  // Place table bits a..g and dp into their bus positions
  always_comb begin
    code        = hex_to_seg(digit);
    seg         = SEG_LOGIC_OFF;
    seg[SEG_A]  = code[6];
    seg[SEG_B]  = code[5];
    seg[SEG_C]  = code[4];
    seg[SEG_D]  = code[3];
    seg[SEG_E]  = code[2];
    seg[SEG_F]  = code[1];
    seg[SEG_G]  = code[0];
    seg[SEG_DP] = dp;
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed N-digit seven-segment driver with double-buffered data,
// anti-ghosting blank interval, per-digit dp/blank and leading-zero suppression.
module seven_segment_scanner
  import seven_segment_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 100000,
  parameter int BLANK_CYCLES   = 16,
  parameter int ACTIVE_LOW_SEG = 1,
  parameter int ACTIVE_LOW_AN  = 1,
  parameter int LZ_SUPPRESS    = 0
) (
  input logic                    clk,
  input logic                    reset,
  seven_segment_scanner_if.slave bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(REFRESH_DIV);

  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]      BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [7:0]            SEG_POL   = (ACTIVE_LOW_SEG != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] AN_POL    =
    (ACTIVE_LOW_AN != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  // With no blank interval the slot starts directly in DRIVE
  localparam scan_phase_t PH_START = (BLANK_CYCLES == 0) ? PH_DRIVE : PH_BLANK;

  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt;
  scan_phase_t             phase, phase_nxt;
  logic                    slot_end, frame_end;

  logic [4*NUM_DIGITS-1:0] pend_value, act_value;
  logic [NUM_DIGITS-1:0]   pend_dp, act_dp, pend_blank, act_blank;
  logic [NUM_DIGITS-1:0]   lz_dark;
  logic                    zero_run;

  logic [3:0]              cur_digit;
  logic                    cur_dp, cur_dark;
  logic [7:0]              dec_seg;
  logic [7:0]              seg_q;
  logic [NUM_DIGITS-1:0]   an_q;

  // Scan state register: slot counter, digit index and phase
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      idx   <= '0;
      phase <= PH_START;
    end else begin
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      phase <= phase_nxt;
    end
  end

  // Next scan state; phase follows the counter value it will hold
  always_comb begin
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    phase_nxt = phase;
    slot_end  = 1'b0;
    frame_end = 1'b0;
    if (!bus.enable) begin
      cnt_nxt   = '0;
      idx_nxt   = '0;
      phase_nxt = PH_START;
    end else begin
      slot_end  = (cnt == CNT_LAST);
      frame_end = slot_end && (idx == IDX_LAST);
      if (slot_end) begin
        cnt_nxt = '0;
        idx_nxt = frame_end ? '0 : idx + 1'b1;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
      phase_nxt = (cnt_nxt < BLANK_END) ? PH_BLANK : PH_DRIVE;
    end
  end

  // Double buffer: load fills pending, the frame boundary publishes it.
  // On a coincident load the old pending is published and the new data waits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_value <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      act_value  <= '0;
      act_dp     <= '0;
      act_blank  <= '0;
    end else begin
      if (frame_end) begin
        act_value <= pend_value;
        act_dp    <= pend_dp;
        act_blank <= pend_blank;
      end
      if (bus.load) begin
        pend_value <= bus.value;
        pend_dp    <= bus.dp_in;
        pend_blank <= bus.blank_in;
      end
    end
  end

  // Leading-zero mask: walk down from the top digit while digits are zero,
  // not forced blank and carry no dp; digit 0 always stays visible
  always_comb begin
    lz_dark  = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (act_value[4*i +: 4] == 4'h0) && !act_blank[i] && !act_dp[i];
      if ((i > 0) && (LZ_SUPPRESS != 0)) lz_dark[i] = zero_run;
    end
  end

  assign cur_digit = act_value[4*idx +: 4];
  assign cur_dp    = act_dp[idx];
  assign cur_dark  = act_blank[idx] | lz_dark[idx];

  seven_segment_decoder u_decoder (
    .digit (cur_digit),
    .dp    (cur_dp),
    .seg   (dec_seg)
  );

  // Registered pin drivers with polarity applied as the final XOR
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_q <= SEG_POL ^ SEG_LOGIC_OFF;
      an_q  <= AN_POL;
    end else if (!bus.enable || (phase == PH_BLANK)) begin
      seg_q <= SEG_POL ^ SEG_LOGIC_OFF;
      an_q  <= AN_POL;
    end else begin
      seg_q <= SEG_POL ^ (cur_dark ? SEG_LOGIC_OFF : dec_seg);
      an_q  <= AN_POL ^ (NUM_DIGITS'(1) << idx);
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.digit_idx  = idx;
  assign bus.frame_tick = frame_end;
  assign bus.phase      = phase;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner (4 digits, 8-cycle slots,
// 2 blank cycles, active-low). dut0 runs without and dut1 with
// leading-zero suppression. Each sampled cycle is the tuple
// {frame_tick, phase==DRIVE, digit_idx, an, seg}.
module tb_seven_segment_scanner;
  import seven_segment_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  seven_segment_scanner_if #(.NUM_DIGITS(4)) bus0 ();
  seven_segment_scanner_if #(.NUM_DIGITS(4)) bus1 ();

  seven_segment_scanner #(
    .NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2),
    .ACTIVE_LOW_SEG(1), .ACTIVE_LOW_AN(1), .LZ_SUPPRESS(0)
  ) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  seven_segment_scanner #(
    .NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2),
    .ACTIVE_LOW_SEG(1), .ACTIVE_LOW_AN(1), .LZ_SUPPRESS(1)
  ) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  string       tag_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          sel    = 1'b0;  // 0 = observe dut0, 1 = observe dut1

  // Logical a..g per hex digit, active-high
  logic [6:0] seg_tbl [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  // Pin level for a digit in DRIVE (active-low segments)
  function automatic logic [7:0] exp_seg(input logic [3:0] d, input logic dp, input logic dark);
    logic [7:0] lg;
    lg = dark ? 8'h00 : {seg_tbl[d], dp};
    return ~lg;
  endfunction

  task automatic push_entry(input logic [15:0] e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Dark display, scan parked at slot 0 BLANK
  task automatic push_idle(input int n, input string tag);
    for (int k = 0; k < n; k++) push_entry({1'b0, 1'b0, 2'd0, 4'hF, 8'hFF}, tag);
  endtask

  // First nsamp samples of a frame starting at digit 0, slot cycle 0.
  // Sample k shows the state the scanner held before edge k, while
  // frame_tick/phase/digit_idx reflect the state after edge k.
  task automatic push_frame(input logic [15:0] val, input logic [3:0] dp,
                            input logic [3:0] dark, input int nsamp, input string tag);
    for (int k = 0; k < nsamp; k++) begin
      int          s, c, st_cnt, st_idx;
      logic [15:0] e;
      s      = k / 8;
      c      = k % 8;
      st_cnt = (k + 1) % 8;
      st_idx = ((k + 1) / 8) % 4;
      e[15]    = (k == 30);
      e[14]    = (st_cnt >= 2);
      e[13:12] = st_idx[1:0];
      e[11:8]  = (c < 2) ? 4'hF : ~(4'b0001 << s);
      e[7:0]   = (c < 2) ? 8'hFF : exp_seg(val[4*s +: 4], dp[s], dark[s]);
      push_entry(e, $sformatf("%s k%0d", tag, k));
    end
  endtask

  task automatic compare_one();
    logic [15:0] exp_v, obs;
    string       tag;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: observed sample with nothing expected");
    end else begin
      exp_v = exp_q.pop_front();
      tag   = tag_q.pop_front();
      obs   = sel ? {bus1.frame_tick, bus1.phase == PH_DRIVE, bus1.digit_idx, bus1.an, bus1.seg}
                  : {bus0.frame_tick, bus0.phase == PH_DRIVE, bus0.digit_idx, bus0.an, bus0.seg};
      assert (obs === exp_v) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
    end
  endtask

  // One sample per clock, 1 time unit after the rising edge
  task automatic consume(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      compare_one();
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic load0(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
    bus0.value    = v;
    bus0.dp_in    = dp;
    bus0.blank_in = bl;
    bus0.load     = 1'b1;
  endtask

  task automatic load1(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
    bus1.value    = v;
    bus1.dp_in    = dp;
    bus1.blank_in = bl;
    bus1.load     = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [15:0] pv, nv;
    logic [3:0]  pdp, ndp, pbl, nbl, v4;

    reset         = 1'b1;
    bus0.enable   = 1'b1;
    bus0.load     = 1'b0;
    bus0.value    = '0;
    bus0.dp_in    = '0;
    bus0.blank_in = '0;
    bus1.enable   = 1'b1;
    bus1.load     = 1'b0;
    bus1.value    = '0;
    bus1.dp_in    = '0;
    bus1.blank_in = '0;

    // Reset state
    push_idle(3, "reset");
    consume(3);
    reset = 1'b0;

    // Frame 1: active still zero even though 1234 is loaded mid-frame
    push_frame(16'h0000, 4'h0, 4'h0, 32, "f1_zero");
    consume(5);
    load0(16'h1234, 4'h0, 4'h0);
    consume(1);
    bus0.load = 1'b0;
    consume(26);

    // Frame 2: shows 1234; stage 9ABC, then load 5678 while frame_tick is high
    push_frame(16'h1234, 4'h0, 4'h0, 32, "f2_1234");
    consume(10);
    load0(16'h9ABC, 4'b0010, 4'h0);
    consume(1);
    bus0.load = 1'b0;
    consume(20);
    load0(16'h5678, 4'h0, 4'h0);
    consume(1);
    bus0.load = 1'b0;

    // Frame 3: old pending (9ABC) published, not the coincident load
    push_frame(16'h9ABC, 4'b0010, 4'h0, 32, "f3_coincide_old");
    consume(32);
    // Frame 4: coincident load appears one frame later
    push_frame(16'h5678, 4'h0, 4'h0, 32, "f4_coincide_new");
    consume(32);

    // Hex sweep: every code through digit 0, dp on digit 3 for odd v,
    // digit 2 forced blank when v == 5
    pv  = 16'h5678;
    pdp = 4'h0;
    pbl = 4'h0;
    for (int v = 0; v < 16; v++) begin
      v4  = 4'(v);
      nv  = {v4 + 4'd1, v4 + 4'd2, v4 + 4'd3, v4};
      ndp = {v4[0], 3'b000};
      nbl = (v == 5) ? 4'b0100 : 4'b0000;
      push_frame(pv, pdp, pbl, 32, $sformatf("hex_prev_v%0d", v));
      consume(5);
      load0(nv, ndp, nbl);
      consume(1);
      bus0.load = 1'b0;
      consume(26);
      pv  = nv;
      pdp = ndp;
      pbl = nbl;
    end
    push_frame(pv, pdp, pbl, 32, "hex_last");
    consume(32);

    // Drop enable in the DRIVE part of digit 2; load while dark
    push_frame(pv, pdp, pbl, 20, "en_pre");
    consume(20);
    bus0.enable = 1'b0;
    push_idle(3, "en_off");
    consume(1);
    load0(16'hCAFE, 4'h0, 4'h0);
    consume(1);
    bus0.load = 1'b0;
    consume(1);
    bus0.enable = 1'b1;
    push_frame(pv, pdp, pbl, 32, "en_restart");
    consume(32);
    push_frame(16'hCAFE, 4'h0, 4'h0, 32, "en_loaded");
    consume(32);

    // Asynchronous reset while digit 1 is driven
    push_frame(16'hCAFE, 4'h0, 4'h0, 12, "rst_pre");
    consume(12);
    reset = 1'b1;
    push_idle(1, "rst_async");
    #1;
    compare_one();
    push_idle(2, "rst_hold");
    consume(2);
    reset = 1'b0;

    // Leading-zero suppression on dut1
    sel = 1'b1;
    push_frame(16'h0000, 4'h0, 4'b1110, 32, "lz_allzero");
    consume(5);
    load1(16'h0050, 4'h0, 4'h0);
    consume(1);
    bus1.load = 1'b0;
    consume(26);

    push_frame(16'h0050, 4'h0, 4'b1100, 32, "lz_0050");
    consume(5);
    load1(16'h0050, 4'b0100, 4'h0);
    consume(1);
    bus1.load = 1'b0;
    consume(26);

    push_frame(16'h0050, 4'b0100, 4'b1000, 32, "lz_dp2");
    consume(32);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover: observed %0d unconsumed expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
